// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_pkg
//  Description : Shared types and helpers for the la_capture logic-analyser
//                core: capture state enumeration and a constant-foldable
//                ceil(log2) used to size address buses.
//  Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

   // Capture controller states
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PRETRIG   = 3'd1,
      S_WAIT_TRIG = 3'd2,
      S_POST      = 3'd3,
      S_DONE      = 3'd4
   } la_state_t;

   // Ceiling log2 with a fixed loop bound so it folds at elaboration time.
   // Returns at least 1 so a degenerate depth still yields a legal bus.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : la_pkg
`default_nettype wire

// File: rtl/la_trig_match.sv
`default_nettype none
// ============================================================================
//  Module      : la_trig_match
//  Description : Trigger comparator for la_capture. Each probe bit either
//                does not participate (mask=0), must equal trig_value
//                (level), or, when LA_EDGE_TRIG_EN is defined and the bit's
//                trig_edge is set, must have just transitioned to
//                trig_value relative to the previous sample. The match
//                output is purely combinational on the current probe.
//  Config      : LA_EDGE_TRIG_EN - adds the previous-sample register and
//                per-bit edge matching; without it only level matching
//                exists and the edge-related ports are absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_trig_match
   import la_pkg::*;
#(
   parameter int PROBE_W = 9
) (
`ifdef LA_EDGE_TRIG_EN
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               sample_i,
   input  logic               clear_i,
   input  logic [PROBE_W-1:0] trig_edge_i,
`endif
   input  logic [PROBE_W-1:0] probe_i,
   input  logic [PROBE_W-1:0] trig_mask_i,
   input  logic [PROBE_W-1:0] trig_value_i,
   output logic               match_o
);

   // Per-bit "this bit is satisfied" vector; the trigger is their AND
   logic [PROBE_W-1:0] bit_ok;

`ifdef LA_EDGE_TRIG_EN
   logic [PROBE_W-1:0] prev_q;
   logic               prev_vld_q;

   // Remember the last sample taken; clearing on arm guarantees the first
   // sample of a capture has no predecessor and so cannot look like an edge
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
      end else if (clear_i) begin
         prev_vld_q <= 1'b0;
      end else if (sample_i) begin
         prev_q     <= probe_i;
         prev_vld_q <= 1'b1;
      end
   end

   for (genvar i = 0; i < PROBE_W; i++) begin : g_bit_edge
      logic lvl_hit;
      logic edge_hit;
      assign lvl_hit  = (probe_i[i] == trig_value_i[i]);
      assign edge_hit = prev_vld_q && (prev_q[i] != trig_value_i[i]) && lvl_hit;
      assign bit_ok[i] = !trig_mask_i[i] || (trig_edge_i[i] ? edge_hit : lvl_hit);
   end
`else
   for (genvar i = 0; i < PROBE_W; i++) begin : g_bit_level
      assign bit_ok[i] = !trig_mask_i[i] || (probe_i[i] == trig_value_i[i]);
   end
`endif

   assign match_o = &bit_ok;

endmodule : la_trig_match
`default_nettype wire

// File: rtl/la_capture.sv
`default_nettype none
// ============================================================================
//  Module      : la_capture
//  Description : On-chip logic-analyser capture core. Samples a PROBE_W-bit
//                probe bus into a DEPTH-word circular buffer whenever
//                sample_en is high during a capture, keeps PRE_TRIG samples
//                ahead of the trigger sample, fills the remainder of the
//                buffer after it, then freezes. The frozen buffer is read by
//                logical index (0 = oldest) with one cycle of latency.
//  Config      : LA_EDGE_TRIG_EN - enables per-bit edge triggering via
//                trig_edge; otherwise trig_edge is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_capture
   import la_pkg::*;
#(
   parameter int PROBE_W  = 9,
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 64
) (
   input  logic                      iclk,
   input  logic                      irst_n,
   input  logic [PROBE_W-1:0]        probe_i,
   input  logic                      sample_en,
   input  logic                      arm,
   input  logic                      abort,
   input  logic [PROBE_W-1:0]        trig_mask,
   input  logic [PROBE_W-1:0]        trig_value,
   input  logic [PROBE_W-1:0]        trig_edge,
   input  logic [clog2(DEPTH)-1:0]   rd_addr,
   output logic [PROBE_W-1:0]        rd_data,
   output logic                      armed,
   output logic                      triggered,
   output logic                      done,
   output logic [clog2(DEPTH)-1:0]   trig_addr
);

   localparam int ADDR_W   = clog2(DEPTH);
   // Samples still to take after the trigger sample to fill the buffer
   localparam int POST_CNT = DEPTH - PRE_TRIG - 1;

   // Terminal counter values; unused variants (e.g. PRE_TRIG = 0) wrap
   // harmlessly because the corresponding state is never entered.
   localparam logic [ADDR_W-1:0] C_PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] C_POST_LAST = ADDR_W'(POST_CNT - 1);
   localparam logic [ADDR_W-1:0] C_PRE_OFF   = ADDR_W'(PRE_TRIG);

   la_state_t          state_q, state_d;
   logic [ADDR_W-1:0]  wptr_q, wptr_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]  trig_addr_q, trig_addr_d;
   logic               triggered_q, triggered_d;
   logic               done_q, done_d;
   logic               armed_q, armed_d;
   logic [PROBE_W-1:0] rd_data_q;

   logic               sample;      // write probe_i into the buffer this cycle
   logic               arm_go;      // accepted arm (abort has priority)
   logic               trig_match;  // trigger condition on the current probe
   logic [ADDR_W-1:0]  rd_phys;     // physical read address

   logic [PROBE_W-1:0] mem [DEPTH];

   // ------------------------------------------------------------------------
   // Trigger comparator
   // ------------------------------------------------------------------------
   la_trig_match #(
      .PROBE_W (PROBE_W)
   ) u_trig_match (
`ifdef LA_EDGE_TRIG_EN
      .clk_i        (iclk),
      .rst_ni       (irst_n),
      .sample_i     (sample),
      .clear_i      (arm_go),
      .trig_edge_i  (trig_edge),
`endif
      .probe_i      (probe_i),
      .trig_mask_i  (trig_mask),
      .trig_value_i (trig_value),
      .match_o      (trig_match)
   );

`ifndef LA_EDGE_TRIG_EN
   // Edge selects have no meaning in a level-only build
   logic unused_trig_edge;
   assign unused_trig_edge = ^trig_edge;
`endif

   // ------------------------------------------------------------------------
   // Capture controller
   // ------------------------------------------------------------------------

   // Next-state logic: abort beats arm, arm restarts from any state, and a
   // sample only advances the capture when sample_en is high
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      cnt_d       = cnt_q;
      trig_addr_d = trig_addr_q;
      triggered_d = triggered_q;
      done_d      = done_q;
      sample      = 1'b0;
      arm_go      = 1'b0;

      if (abort) begin
         state_d     = S_IDLE;
         triggered_d = 1'b0;
         done_d      = 1'b0;
      end else if (arm) begin
         arm_go      = 1'b1;
         wptr_d      = '0;
         cnt_d       = '0;
         triggered_d = 1'b0;
         done_d      = 1'b0;
         state_d     = (PRE_TRIG == 0) ? S_WAIT_TRIG : S_PRETRIG;
      end else if (sample_en) begin
         case (state_q)
            S_PRETRIG: begin
               // Fill the pre-trigger window; matches here are ignored
               sample = 1'b1;
               wptr_d = wptr_q + 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == C_PRE_LAST) begin
                  cnt_d   = '0;
                  state_d = S_WAIT_TRIG;
               end
            end
            S_WAIT_TRIG: begin
               // Keep overwriting the ring until the trigger fires
               sample = 1'b1;
               wptr_d = wptr_q + 1'b1;
               if (trig_match) begin
                  trig_addr_d = wptr_q;
                  triggered_d = 1'b1;
                  cnt_d       = '0;
                  if (POST_CNT == 0) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_POST;
                  end
               end
            end
            S_POST: begin
               sample = 1'b1;
               wptr_d = wptr_q + 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == C_POST_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
            default: begin
               // IDLE and DONE take no samples
            end
         endcase
      end

      armed_d = (state_d == S_PRETRIG) || (state_d == S_WAIT_TRIG) ||
                (state_d == S_POST);
   end

   // State and status registers, all updated on the same edge
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         cnt_q       <= '0;
         trig_addr_q <= '0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         cnt_q       <= cnt_d;
         trig_addr_q <= trig_addr_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
         armed_q     <= armed_d;
      end
   end

   // ------------------------------------------------------------------------
   // Capture buffer (simple dual-port, synchronous read)
   // ------------------------------------------------------------------------

   // Write port: contents are deliberately not reset so this maps to BRAM
   always_ff @(posedge iclk) begin
      if (sample) begin
         mem[wptr_q] <= probe_i;
      end
   end

   // Logical index 0 is the oldest sample, PRE_TRIG before the trigger
   assign rd_phys = trig_addr_q - C_PRE_OFF + rd_addr;

   // Registered read port with a resettable output register
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_phys];
      end
   end

   assign rd_data   = rd_data_q;
   assign armed     = armed_q;
   assign triggered = triggered_q;
   assign done      = done_q;
   assign trig_addr = trig_addr_q;

endmodule : la_capture
`default_nettype wire

// File: tb/tb_la_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_capture
//  Description : Self-checking bench for la_capture (PROBE_W=9, DEPTH=16,
//                PRE_TRIG=4). A history-based reference model records every
//                sample taken since arm, locates the trigger by index and
//                predicts flags, trigger address and readout contents.
//  Config      : LA_EDGE_TRIG_EN - also models and exercises edge triggers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_capture;

   localparam int PROBE_W  = 9;
   localparam int DEPTH    = 16;
   localparam int PRE_TRIG = 4;
   localparam int ADDR_W   = 4;

   logic               iclk       = 1'b0;
   logic               irst_n     = 1'b0;
   logic [PROBE_W-1:0] probe_i    = '0;
   logic               sample_en  = 1'b0;
   logic               arm        = 1'b0;
   logic               abort      = 1'b0;
   logic [PROBE_W-1:0] trig_mask  = '0;
   logic [PROBE_W-1:0] trig_value = '0;
   logic [PROBE_W-1:0] trig_edge  = '0;
   logic [ADDR_W-1:0]  rd_addr    = '0;
   logic [PROBE_W-1:0] rd_data;
   logic               armed, triggered, done;
   logic [ADDR_W-1:0]  trig_addr;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: all samples since the last arm, plus derived status
   logic [PROBE_W-1:0] hist [$];
   bit                 m_armed = 1'b0;
   bit                 m_trig  = 1'b0;
   bit                 m_done  = 1'b0;
   int                 m_tidx  = 0;
   logic [ADDR_W-1:0]  m_taddr = '0;

   always #5 iclk = ~iclk;

   la_capture #(
      .PROBE_W  (PROBE_W),
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE_TRIG)
   ) dut (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .probe_i    (probe_i),
      .sample_en  (sample_en),
      .arm        (arm),
      .abort      (abort),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .trig_edge  (trig_edge),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .armed      (armed),
      .triggered  (triggered),
      .done       (done),
      .trig_addr  (trig_addr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Does history entry i satisfy the trigger rule?
   function automatic bit m_match(input int i);
      logic [PROBE_W-1:0] cur;
      logic [PROBE_W-1:0] prv;
      cur = hist[i];
      prv = (i > 0) ? hist[i-1] : '0;
      for (int b = 0; b < PROBE_W; b++) begin
         if (trig_mask[b]) begin
`ifdef LA_EDGE_TRIG_EN
            if (trig_edge[b]) begin
               if (i == 0 || prv[b] == trig_value[b] || cur[b] != trig_value[b]) return 1'b0;
            end else
`endif
            if (cur[b] != trig_value[b]) return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   // Probe pattern for the next sample, by pattern id
   function automatic logic [PROBE_W-1:0] gen(input int mode);
      int n;
      n = hist.size();
      case (mode)
         0:       return PROBE_W'(n);
         1:       return (n == 2 || n == 40) ? 9'h002 : PROBE_W'(9'h100 | n);
         3:       return (n == 10) ? 9'h000 : 9'h001;
         default: return PROBE_W'($urandom);
      endcase
   endfunction

   // One clock: drive at negedge, update model at posedge, check just after
   task automatic step(input bit a, input bit ab, input logic [PROBE_W-1:0] p, input bit sen);
      @(negedge iclk);
      arm = a; abort = ab; probe_i = p; sample_en = sen;
      @(posedge iclk);
      if (ab) begin
         m_armed = 0; m_trig = 0; m_done = 0;
      end else if (a) begin
         hist.delete();
         m_armed = 1; m_trig = 0; m_done = 0;
      end else if (m_armed && sen) begin
         hist.push_back(p);
         if (!m_trig && (hist.size() - 1) >= PRE_TRIG && m_match(hist.size() - 1)) begin
            m_trig  = 1;
            m_tidx  = hist.size() - 1;
            m_taddr = ADDR_W'(m_tidx % DEPTH);
         end
         if (m_trig && hist.size() == m_tidx + DEPTH - PRE_TRIG) begin
            m_done  = 1;
            m_armed = 0;
         end
      end
      #1;
      check("armed", armed, m_armed);
      check("triggered", triggered, m_trig);
      check("done", done, m_done);
      check("trig_addr", trig_addr, m_taddr);
      arm = 0; abort = 0;
   endtask

   task automatic run_capture(input int mode, input bit rnd_sen, input bit restarts);
      int budget;
      budget = 600;
      step(1'b1, 1'b0, gen(mode), 1'b1);
      while (!m_done && budget > 0) begin
         step(restarts && ($urandom_range(0, 49) == 0), 1'b0, gen(mode),
              rnd_sen ? ($urandom_range(0, 3) != 0) : 1'b1);
         budget--;
      end
      if (!m_done) check("capture_timeout", done, 1);
   endtask

   task automatic read_one(input int idx, output logic [PROBE_W-1:0] d);
      @(negedge iclk);
      rd_addr = ADDR_W'(idx);
      @(posedge iclk);
      #1;
      d = rd_data;
   endtask

   // Read every logical index in shuffled order against the model
   task automatic read_all();
      int order [DEPTH];
      logic [PROBE_W-1:0] d;
      for (int i = 0; i < DEPTH; i++) order[i] = i;
      for (int i = 0; i < DEPTH; i++) begin
         int j, t;
         j = $urandom_range(0, DEPTH - 1);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int k = 0; k < DEPTH; k++) begin
         read_one(order[k], d);
         check("rd_data", d, hist[m_tidx - PRE_TRIG + order[k]]);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PROBE_W-1:0] d;
      int k;

      // Reset values
      irst_n = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      check("rst_armed", armed, 0);
      check("rst_triggered", triggered, 0);
      check("rst_done", done, 0);
      check("rst_trig_addr", trig_addr, 0);
      check("rst_rd_data", rd_data, 0);
      @(negedge iclk);
      irst_n = 1'b1;

      // Basic capture
      trig_mask = 9'h1FF; trig_value = 9'h010; trig_edge = '0;
      run_capture(0, 1'b0, 1'b0);
      check("basic_trig_addr", trig_addr, 0);
      read_one(0, d);  check("basic_idx0", d, 9'h00C);
      read_one(4, d);  check("basic_idx4", d, 9'h010);
      read_one(15, d); check("basic_idx15", d, 9'h01B);
      read_all();

      // Match during PRETRIG is ignored
      trig_value = 9'h002;
      run_capture(1, 1'b0, 1'b0);
      check("pretrig_trig_addr", trig_addr, 8);
      read_one(4, d); check("pretrig_idx4", d, 9'h002);
      read_all();

      // Single-bit mask
      trig_mask = 9'h001; trig_value = 9'h001;
      run_capture(0, 1'b0, 1'b0);
      check("mask_trig_addr", trig_addr, 5);
      read_one(0, d); check("mask_idx0", d, 9'h001);
      read_one(4, d); check("mask_idx4", d, 9'h005);
      read_all();

      // Abort two cycles into POST, then a fresh full capture
      trig_mask = 9'h1FF; trig_value = 9'h010;
      step(1'b1, 1'b0, gen(0), 1'b1);
      k = 0;
      while (!m_trig && k < 100) begin
         step(1'b0, 1'b0, gen(0), 1'b1);
         k++;
      end
      step(1'b0, 1'b0, gen(0), 1'b1);
      step(1'b0, 1'b0, gen(0), 1'b1);
      step(1'b0, 1'b1, gen(0), 1'b1);
      check("abort_armed", armed, 0);
      check("abort_triggered", triggered, 0);
      check("abort_done", done, 0);
      run_capture(0, 1'b0, 1'b0);
      check("rearm_done", done, 1);
      read_all();

      // Reset while waiting for a trigger
      trig_value = 9'h1FF;
      step(1'b1, 1'b0, gen(0), 1'b1);
      repeat (6) step(1'b0, 1'b0, gen(0), 1'b1);
      check("wait_armed", armed, 1);
      @(negedge iclk);
      irst_n = 1'b0;
      @(posedge iclk);
      #1;
      hist.delete();
      m_armed = 0; m_trig = 0; m_done = 0; m_taddr = '0;
      check("midrst_armed", armed, 0);
      check("midrst_done", done, 0);
      check("midrst_trig_addr", trig_addr, 0);
      @(negedge iclk);
      irst_n = 1'b1;
      // arm together with abort stays idle
      step(1'b1, 1'b1, gen(0), 1'b1);
      step(1'b0, 1'b0, gen(0), 1'b1);
      check("armabort_armed", armed, 0);

`ifdef LA_EDGE_TRIG_EN
      // Edge trigger: steady high gives nothing, a 0->1 transition fires
      trig_mask = 9'h001; trig_value = 9'h001; trig_edge = 9'h001;
      run_capture(3, 1'b0, 1'b0);
      check("edge_trig_addr", trig_addr, 11);
      read_one(3, d); check("edge_idx3", d, 9'h000);
      read_one(4, d); check("edge_idx4", d, 9'h001);
      read_all();
`endif

      // Randomised captures: sparse masks, decimation, occasional re-arm
      for (int r = 0; r < 8; r++) begin
         trig_mask  = '0;
         for (int b = 0; b < 3; b++) trig_mask[$urandom_range(0, PROBE_W - 1)] = 1'b1;
         trig_value = PROBE_W'($urandom);
         trig_edge  = PROBE_W'($urandom);
         run_capture(2, 1'b1, 1'b1);
         read_all();
      end

      // All-zero mask fires on the first eligible sample
      trig_mask = '0;
      run_capture(2, 1'b1, 1'b0);
      check("zeromask_trig_addr", trig_addr, PRE_TRIG);
      read_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_la_capture
`default_nettype wire
